fifo_cmd_ctrl: RTL and testbench

//  Upstream command stage for fifo_top. Turns a push port (wr_req/wr_data) and a pop port (rd_req)

---
 rtl/fifo_cmd_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_cmd_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_cmd_ctrl.sv
// Command front end for fifo_top: push/pop arbitration, occupancy count, read return.
// Optional grant counters: define FIFO_CMD_STATS_EN.
module fifo_cmd_ctrl #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_ENTRIES  = 4,
    parameter int OPCODE_WIDTH = 2,
    parameter int CNT_WIDTH    = $clog2(NUM_ENTRIES) + 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_req,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             wr_ready,
    input  logic                             rd_req,
    output logic                             rd_ready,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out,
    input  logic [DATA_WIDTH-1:0]            fifo_dout,
`ifdef FIFO_CMD_STATS_EN
    output logic [15:0]                      wr_total,
    output logic [15:0]                      rd_total,
`endif
    output logic [CNT_WIDTH-1:0]             level
);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]    FULL     = CNT_WIDTH'(NUM_ENTRIES);

    typedef enum logic {PRIO_WR, PRIO_RD} prio_t;

    prio_t       prio, prio_next;
    logic        wr_ok, rd_ok, collide;
    logic        wr_grant, rd_grant;
    logic [1:0]  rd_pipe;

    always_comb begin
        wr_ok     = (level != FULL);
        rd_ok     = (level != '0);
        collide   = wr_req && rd_req && wr_ok && rd_ok;
        // The losing side of a live collision sees ready low.
        wr_ready  = !reset && wr_ok && !(rd_req && rd_ok && prio == PRIO_RD);
        rd_ready  = !reset && rd_ok && !(wr_req && wr_ok && prio == PRIO_WR);
        wr_grant  = wr_req && wr_ready;
        rd_grant  = rd_req && rd_ready;
        prio_next = prio;
        if (collide) begin
            prio_next = (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= PRIO_WR;
        end else begin
            prio <= prio_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vector_out <= '0;
            level      <= '0;
            rd_pipe    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr_grant) begin
                vector_out <= {OP_WRITE, wr_data};
                level      <= level + 1'b1;
            end else if (rd_grant) begin
                vector_out <= {OP_READ, {DATA_WIDTH{1'b0}}};
                level      <= level - 1'b1;
            end else begin
                vector_out <= {OP_NOP, {DATA_WIDTH{1'b0}}};
            end
            // fifo_top executes one edge after the grant and registers data_out.
            rd_pipe  <= {rd_pipe[0], rd_grant};
            rd_valid <= rd_pipe[1];
            if (rd_pipe[1]) begin
                rd_data <= fifo_dout;
            end
        end
    end

`ifdef FIFO_CMD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_total <= '0;
            rd_total <= '0;
        end else begin
            if (wr_grant && wr_total != 16'hFFFF) begin
                wr_total <= wr_total + 16'd1;
            end
            if (rd_grant && rd_total != 16'hFFFF) begin
                rd_total <= rd_total + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_cmd_ctrl.sv
// Directed vector bench for fifo_cmd_ctrl with a small behavioural fifo_top model.
// Covers fill, drain, collisions, empty pop and async reset during a read.
module tb_fifo_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [3:0] wr_data = '0;
    logic       wr_ready;
    logic       rd_req = 1'b0;
    logic       rd_ready;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [5:0] vector_out;
    logic [3:0] fifo_dout;
    logic [2:0] level;
`ifdef FIFO_CMD_STATS_EN
    logic [15:0] wr_total;
    logic [15:0] rd_total;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_cmd_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .vector_out (vector_out),
        .fifo_dout  (fifo_dout),
`ifdef FIFO_CMD_STATS_EN
        .wr_total   (wr_total),
        .rd_total   (rd_total),
`endif
        .level      (level)
    );

    // fifo_top model: executes the opcode sampled at each edge, registered output.
    logic [3:0] q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            fifo_dout <= '0;
        end else if (vector_out[5:4] == 2'b10) begin
            q.push_back(vector_out[3:0]);
        end else if (vector_out[5:4] == 2'b01 && q.size() > 0) begin
            fifo_dout <= q.pop_front();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] d;
        logic       rd;
        logic       ewr;
        logic       erd;
        logic [5:0] evec;
        logic [2:0] elvl;
        logic       erv;
        logic [3:0] edat;
    } vec_t;

    vec_t tv[19];

    initial begin
        tv[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 6'b10_0001, 3'd1, 1'b0, 4'h0};
        tv[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 6'b10_0010, 3'd2, 1'b0, 4'h0};
        tv[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 6'b10_0011, 3'd3, 1'b0, 4'h0};
        tv[3]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 6'b10_0100, 3'd4, 1'b0, 4'h0};
        tv[4]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 6'b00_0000, 3'd4, 1'b0, 4'h0};
        tv[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 6'b01_0000, 3'd3, 1'b0, 4'h0};
        tv[6]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 6'b01_0000, 3'd2, 1'b0, 4'h0};
        tv[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 6'b01_0000, 3'd1, 1'b1, 4'h1};
        tv[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 6'b01_0000, 3'd0, 1'b1, 4'h2};
        tv[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 6'b00_0000, 3'd0, 1'b1, 4'h3};
        tv[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 6'b00_0000, 3'd0, 1'b1, 4'h4};
        tv[11] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 6'b10_1001, 3'd1, 1'b0, 4'h0};
        tv[12] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 6'b10_1010, 3'd2, 1'b0, 4'h0};
        tv[13] = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 6'b01_0000, 3'd1, 1'b0, 4'h0};
        tv[14] = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 6'b10_1011, 3'd2, 1'b0, 4'h0};
        tv[15] = '{1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 6'b01_0000, 3'd1, 1'b1, 4'h9};
        tv[16] = '{1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 6'b10_1100, 3'd2, 1'b0, 4'h0};
        tv[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 6'b00_0000, 3'd2, 1'b1, 4'hA};
        tv[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 6'b00_0000, 3'd2, 1'b0, 4'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("init_vec", 32'(vector_out), 32'h00);
        chk("init_level", 32'(level), 32'd0);
        chk("init_rv", 32'(rd_valid), 32'd0);
        chk("init_wr_ready", 32'(wr_ready), 32'd1);
        chk("init_rd_ready", 32'(rd_ready), 32'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            wr_req  = tv[i].wr;
            wr_data = tv[i].d;
            rd_req  = tv[i].rd;
            #1;
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(tv[i].ewr));
            chk($sformatf("v%0d_rd_ready", i), 32'(rd_ready), 32'(tv[i].erd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vec", i), 32'(vector_out), 32'(tv[i].evec));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tv[i].elvl));
            chk($sformatf("v%0d_rv", i), 32'(rd_valid), 32'(tv[i].erv));
            if (tv[i].erv) begin
                chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(tv[i].edat));
            end
        end

        // Async reset one clock after a read grant: the strobe must never appear
        @(negedge clk);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        chk("r6_grant_vec", 32'(vector_out), 32'h10);
        @(negedge clk);
        rd_req = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("r6_async_vec", 32'(vector_out), 32'h00);
        chk("r6_async_level", 32'(level), 32'd0);
        chk("r6_async_rv", 32'(rd_valid), 32'd0);
        chk("r6_async_wr_ready", 32'(wr_ready), 32'd0);
        chk("r6_async_rd_ready", 32'(rd_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r6_post_wr_ready", 32'(wr_ready), 32'd1);
        chk("r6_post_rd_ready", 32'(rd_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("r6_no_rv_%0d", k), 32'(rd_valid), 32'd0);
            chk($sformatf("r6_vec_%0d", k), 32'(vector_out), 32'h00);
        end

`ifdef FIFO_CMD_STATS_EN
        chk("st_wr_zero", 32'(wr_total), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            wr_data = 4'(k);
        end
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("st_wr_total", 32'(wr_total), 32'd3);
        chk("st_rd_total", 32'(rd_total), 32'd1);
        chk("st_level", 32'(level), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
